// File: rtl/period_meter.sv
// period_meter: measures period and high time of an asynchronous square wave
// in system-clock cycles, with a one-cycle valid strobe and a stall timeout.
module period_meter #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 100_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,      // asynchronous, active-low
  input  logic                   i_enable,
  input  logic                   i_sig_in,
  output logic [COUNT_WIDTH-1:0] o_period,
  output logic [COUNT_WIDTH-1:0] o_high_time,
  output logic                   o_valid,
  output logic                   o_timeout,
  output logic                   o_busy
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_s1;
  logic                   r_s2;
  logic                   r_s3;
  logic                   w_rise;

  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_hcnt;
  logic [COUNT_WIDTH-1:0] r_period;
  logic [COUNT_WIDTH-1:0] r_high_time;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_busy;

  logic [COUNT_WIDTH-1:0] w_cnt_sat_inc;
  logic [COUNT_WIDTH-1:0] w_hcnt_sat_inc;
  logic [COUNT_WIDTH-1:0] w_cnt_nxt;
  logic [COUNT_WIDTH-1:0] w_hcnt_nxt;
  logic [COUNT_WIDTH-1:0] w_period_nxt;
  logic [COUNT_WIDTH-1:0] w_high_time_nxt;
  logic                   w_valid_nxt;
  logic                   w_timeout_nxt;

  // Two-flop synchronizer plus edge-history flop for rising-edge detection
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  // Saturating increments; counters never wrap
  assign w_cnt_sat_inc  = (r_cnt  == CNT_MAX) ? r_cnt  : r_cnt  + CNT_ONE;
  assign w_hcnt_sat_inc = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_ONE;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and output-register next values
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hcnt_nxt      = r_hcnt;
    w_period_nxt    = r_period;
    w_high_time_nxt = r_high_time;
    w_valid_nxt     = 1'b0;
    w_timeout_nxt   = r_timeout;

    if (!i_enable) begin
      // Abandon any measurement; results and timeout flag are kept
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_hcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt  = '0;
          w_hcnt_nxt = '0;
          if (w_rise) begin
            // First edge only starts the count; no result yet
            w_state_nxt = ST_MEASURE;
            w_cnt_nxt   = CNT_ONE;
            w_hcnt_nxt  = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            // Edge wins over a coincident timeout condition
            w_period_nxt    = r_cnt;
            w_high_time_nxt = r_hcnt;
            w_valid_nxt     = 1'b1;
            w_timeout_nxt   = 1'b0;
            w_cnt_nxt       = CNT_ONE;
            w_hcnt_nxt      = CNT_ONE;
          end else if (r_cnt >= TIMEOUT_C) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_hcnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_sat_inc;
            if (r_s2) begin
              w_hcnt_nxt = w_hcnt_sat_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Counters and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_hcnt      <= w_hcnt_nxt;
      r_period    <= w_period_nxt;
      r_high_time <= w_high_time_nxt;
      r_valid     <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt == ST_MEASURE);
    end
  end

  assign o_period    = r_period;
  assign o_high_time = r_high_time;
  assign o_valid     = r_valid;
  assign o_timeout   = r_timeout;
  assign o_busy      = r_busy;

endmodule
